// File: rtl/cdm_bus_pkg.sv
// Shared types and constants for the load/store bus sequencer.
// The fault code mirrors the core's exception vector entry for unaligned access.
package cdm_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BEAT = 2'd1,
        RESP = 2'd2
    } seq_state_t;

    localparam int SZ_BYTE = 0;
    localparam int SZ_HALF = 1;
    localparam int SZ_WORD = 2;

    localparam int FAULT_UNALIGNED = 2;

    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/cdm_bus_sequencer_if.sv
// Core request/response and external byte-bus signals of the sequencer.
// master = core + memory side, slave = sequencer.
interface cdm_bus_sequencer_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int BUS_W  = 16
);
    localparam int SZ_W = $clog2(DATA_W / 8) + 1;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [SZ_W-1:0]   req_size;
    logic              req_sign;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_fault;
    logic              bus_valid;
    logic              bus_ready;
    logic              bus_write;
    logic [ADDR_W-1:0] bus_addr;
    logic [BUS_W/8-1:0] bus_be;
    logic [BUS_W-1:0]  bus_wdata;
    logic [BUS_W-1:0]  bus_rdata;

    modport master (
        output req_valid, req_write, req_size, req_sign, req_addr, req_wdata,
        output bus_ready, bus_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault,
        input  bus_valid, bus_write, bus_addr, bus_be, bus_wdata
    );

    modport slave (
        input  req_valid, req_write, req_size, req_sign, req_addr, req_wdata,
        input  bus_ready, bus_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault,
        output bus_valid, bus_write, bus_addr, bus_be, bus_wdata
    );

endinterface

// File: rtl/cdm_lane_align.sv
// Per-beat lane mapping: byte enables, write-data placement and read-data merge.
// Byte rel of the access lands on lane j when rel = beat*BB + j - off.
module cdm_lane_align #(
    parameter int DATA_W = 16,
    parameter int BUS_W  = 16,
    parameter int OFF_W  = 1,
    parameter int BEAT_W = 2,
    parameter int SZ_W   = 2
) (
    input  logic [BEAT_W-1:0]  i_beat,
    input  logic [OFF_W-1:0]   i_off,
    input  logic [SZ_W-1:0]    i_size,
    input  logic [DATA_W-1:0]  i_wdata,
    input  logic [BUS_W-1:0]   i_rdata,
    input  logic [DATA_W-1:0]  i_asm,
    output logic [BUS_W/8-1:0] o_be,
    output logic [BUS_W-1:0]   o_wdata,
    output logic [DATA_W-1:0]  o_asm
);
    localparam int BB = BUS_W / 8;
    localparam int DB = DATA_W / 8;

    int w_nbytes;
    int w_first;
    int w_rel;

    always_comb begin
        o_be     = '0;
        o_wdata  = '0;
        o_asm    = i_asm;
        w_nbytes = 1 << i_size;
        w_first  = int'(i_beat) * BB - int'(i_off);
        w_rel    = 0;
        for (int j = 0; j < BB; j++) begin
            w_rel = w_first + j;
            if (w_rel >= 0 && w_rel < w_nbytes) begin
                o_be[j] = 1'b1;
                for (int i = 0; i < DB; i++) begin
                    if (i == w_rel) begin
                        o_wdata[8*j +: 8] = i_wdata[8*i +: 8];
                        o_asm[8*i +: 8]   = i_rdata[8*j +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/cdm_bus_sequencer.sv
// Splits core load/store micro-ops into aligned bus beats and reassembles loads.
//   state | meaning
//   IDLE  | ready for a request; decode size/offset/fault on accept
//   BEAT  | drive beat k until bus_ready, merge read lanes
//   RESP  | one-cycle response with extended data or fault
module cdm_bus_sequencer
    import cdm_bus_pkg::*;
#(
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16,
    parameter int BUS_W           = 16,
    parameter int ALLOW_UNALIGNED = 1
) (
    input logic clk,
    input logic rst,
    cdm_bus_sequencer_if.slave bif
);
    localparam int BB        = BUS_W / 8;
    localparam int DB        = DATA_W / 8;
    localparam int LOG_DB    = $clog2(DB);
    localparam int SZ_W      = LOG_DB + 1;
    localparam int OFF_W     = clog2_min1(BB);
    localparam int MAX_BEATS = DB / BB + 1;
    localparam int BEAT_W    = $clog2(MAX_BEATS + 1);

    seq_state_t        r_state, w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [SZ_W-1:0]   r_size;
    logic              r_sign, r_write, r_fault;
    logic [DATA_W-1:0] r_wdata, r_asm;
    logic [BEAT_W-1:0] r_beat, r_nbeats;

    int                w_req_nbytes, w_req_off, w_req_beats, w_nbytes;
    logic              w_req_fault, w_last, w_sbit;
    logic [BUS_W/8-1:0] w_be;
    logic [BUS_W-1:0]  w_wdata;
    logic [DATA_W-1:0] w_asm_next, w_ext;

    always_comb begin
        w_req_nbytes = 1 << bif.req_size;
        w_req_off    = int'(bif.req_addr & ADDR_W'(BB - 1));
        w_req_beats  = (w_req_off + w_req_nbytes + BB - 1) / BB;
        w_req_fault  = (bif.req_size > SZ_W'(LOG_DB)) ||
                       ((ALLOW_UNALIGNED == 0) &&
                        ((bif.req_addr & ADDR_W'(w_req_nbytes - 1)) != '0));
    end

    cdm_lane_align #(
        .DATA_W(DATA_W), .BUS_W(BUS_W), .OFF_W(OFF_W), .BEAT_W(BEAT_W), .SZ_W(SZ_W)
    ) u_lane_align (
        .i_beat (r_beat),
        .i_off  (r_addr[OFF_W-1:0] & OFF_W'(BB - 1)),
        .i_size (r_size),
        .i_wdata(r_wdata),
        .i_rdata(bif.bus_rdata),
        .i_asm  (r_asm),
        .o_be   (w_be),
        .o_wdata(w_wdata),
        .o_asm  (w_asm_next)
    );

    assign w_last = (r_beat == r_nbeats - BEAT_W'(1));

    // Extension bit is the top bit of the accessed width, not of DATA_W.
    always_comb begin
        w_nbytes = 1 << r_size;
        w_sbit   = 1'b0;
        w_ext    = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i == 8 * w_nbytes - 1) w_sbit = r_asm[i];
        end
        for (int i = 0; i < DATA_W; i++) begin
            w_ext[i] = (i < 8 * w_nbytes) ? r_asm[i] : (r_sign & w_sbit);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        bif.req_ready = 1'b0;
        bif.rsp_valid = 1'b0;
        bif.rsp_fault = 1'b0;
        bif.rsp_rdata = '0;
        bif.bus_valid = 1'b0;
        bif.bus_write = 1'b0;
        bif.bus_addr  = '0;
        bif.bus_be    = '0;
        bif.bus_wdata = '0;
        case (r_state)
            IDLE: begin
                bif.req_ready = 1'b1;
                if (bif.req_valid) w_next = w_req_fault ? RESP : BEAT;
            end
            BEAT: begin
                bif.bus_valid = 1'b1;
                bif.bus_write = r_write;
                bif.bus_addr  = (r_addr & ~ADDR_W'(BB - 1)) + ADDR_W'(int'(r_beat) * BB);
                bif.bus_be    = w_be;
                bif.bus_wdata = w_wdata;
                if (bif.bus_ready && w_last) w_next = RESP;
            end
            RESP: begin
                bif.rsp_valid = 1'b1;
                bif.rsp_fault = r_fault;
                bif.rsp_rdata = (r_fault || r_write) ? '0 : w_ext;
                w_next        = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr   <= '0;
            r_size   <= '0;
            r_sign   <= 1'b0;
            r_write  <= 1'b0;
            r_fault  <= 1'b0;
            r_wdata  <= '0;
            r_asm    <= '0;
            r_beat   <= '0;
            r_nbeats <= '0;
        end else if (r_state == IDLE && bif.req_valid) begin
            r_addr   <= bif.req_addr;
            r_size   <= bif.req_size;
            r_sign   <= bif.req_sign;
            r_write  <= bif.req_write;
            r_fault  <= w_req_fault;
            r_wdata  <= bif.req_wdata;
            r_asm    <= '0;
            r_beat   <= '0;
            r_nbeats <= BEAT_W'(w_req_beats);
        end else if (r_state == BEAT && bif.bus_ready) begin
            r_asm  <= w_asm_next;
            r_beat <= r_beat + BEAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && r_state == IDLE && bif.req_valid && !w_req_fault)
            assert (w_req_beats <= MAX_BEATS);
    end

endmodule

// File: doc/cdm_bus_sequencer.md
Name: cdm_bus_sequencer

Overview:
- Parametrised memory-access sequencer between the CPU core's load/store micro-ops and a byte-addressable external bus.
- Generalises the core's current two-phase unaligned-word handling to any data and bus width. Adds multi-beat splitting, a wait-state handshake, sign or zero extension, and misalignment faulting.
- Sits where the core's address/data_in/data_out/word/read signals meet memory.
- The core stalls while req_ready is low. It treats rsp_fault like its existing unaligned-SP/PC exception.

Parameters:
- ADDR_W, 16, address width in bits; addresses are byte addresses.
- DATA_W, 16, widest access in bits; a power of two, multiple of 8, ≥ BUS_W.
- BUS_W, 16, external bus width in bits; a power of two, ≥ 8.
- ALLOW_UNALIGNED, 1: 1 = split unaligned accesses into beats; 0 = fault on any unaligned access.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  access request from core.
- req_ready  out  1  sequencer idle and accepting a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  $clog2(DATA_W/8)+1  log2 of access bytes (0 = byte, 1 = half, ...).
- req_sign  in  1  sign-extend load result.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-justified.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  load result, extended; 0 for stores and faults.
- rsp_fault  out  1  access rejected; qualified by rsp_valid.
- bus_valid  out  1  beat request.
- bus_ready  in  1  beat accepted/complete this cycle.
- bus_write  out  1  beat is a write.
- bus_addr  out  ADDR_W  beat address, aligned to BUS_W/8.
- bus_be  out  BUS_W/8  byte-lane enables.
- bus_wdata  out  BUS_W  write data in lane position; disabled lanes driven 0.
- bus_rdata  in  BUS_W  read data, sampled when bus_valid & bus_ready.

Behaviour:
- Synchronous reset, one clock, active-high as decided.
- In the cycle after rst is sampled high, outputs take these values:
  - req_ready=1.
  - rsp_valid=0, rsp_fault=0, rsp_rdata=0.
  - bus_valid=0, bus_write=0, bus_addr=0, bus_be=0, bus_wdata=0.
- Reset mid-beat abandons the access; no response is produced.
- FSM states are IDLE, BEAT and RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr, size, sign, write and wdata.
  - Compute nbytes = 1<<req_size, off = addr mod (BUS_W/8), and beats = ceil((off+nbytes)/(BUS_W/8)).
  - Fault when nbytes > DATA_W/8, or when ALLOW_UNALIGNED=0 and addr mod nbytes ≠ 0. A faulting request goes to RESP with the fault flag set and issues no beats.
  - Otherwise go to BEAT.
- BEAT:
  - Drive bus_valid=1. bus_addr = (addr − off) + k·(BUS_W/8) for beat k, modulo 2^ADDR_W, so the address wraps.
  - bus_be enables only the bytes of [addr, addr+nbytes) that fall in this beat.
  - All bus outputs stay stable until bus_ready. Wait states are unbounded.
  - On bus_valid & bus_ready: merge the enabled read lanes into the assembly register at their byte index relative to addr, then increment k.
  - After the last beat go to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle.
  - rsp_rdata holds the assembled bytes, zero-extended, or sign-extended from bit 8·nbytes−1 when req_sign=1.
  - Return to IDLE; req_ready is 0 during RESP.
- Byte order is little-endian: lower address maps to lower lanes and lower result bits.
- Latency with zero wait states: request accepted at cycle N, first beat at N+1, rsp_valid at N+beats+1. A fault gives rsp_valid at N+1.
- req_valid is ignored outside IDLE. A request arriving in the same cycle as rst is dropped.
- A request with beats > DATA_W/BUS_W+1 is impossible by construction; an assertion checks it.

Decomposition:
- Shared package cdm_bus_pkg holds:
  - the state enum (IDLE/BEAT/RESP);
  - the size encoding constants (SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2);
  - the fault code constant, shared with the core's exception vector table (unaligned access = 2).
- One sub-module, cdm_lane_align: combinational per-beat byte-enable and lane shift for both write data and read merge, parametrised by BUS_W and DATA_W.
- Beat counter and FSM stay in the top level.

Test Plan (DATA_W=BUS_W=16 unless noted):
1. Aligned read, addr 0x0010, size 1, bus_ready held 1, bus_rdata 0xBEEF → one beat with bus_addr 0x0010 and be 2'b11; rsp_valid at N+2 with rsp_rdata 0xBEEF, fault 0.
2. Unaligned read, addr 0x0011, size 1:
   - beat 0: bus_addr 0x0010, be 2'b10, rdata 0x12AB;
   - beat 1: bus_addr 0x0012, be 2'b01, rdata 0xCD34;
   - → rsp_rdata 0x3412 at N+3.
3. Unaligned write, addr 0x0011, wdata 0xA55A:
   - beat 0: be 2'b10, wdata 0x5A00;
   - beat 1: be 2'b01, wdata 0x00A5;
   - → rsp_valid with rdata 0.
4. Byte read, addr 0x0003, bus_rdata 0x80FF: with sign=1 → 0xFF80; with sign=0 → 0x0080. bus_be is 2'b10 in both cases.
5. Wait states: test 1 with bus_ready low for 3 cycles → bus_addr/be/valid stay stable, rsp_valid at N+5. Then assert rst during a second access's beat → next cycle bus_valid=0, req_ready=1, no rsp_valid.
6. Wrap and fault:
   - word read at 0xFFFF → beats at 0xFFFE then 0x0000;
   - same request with ALLOW_UNALIGNED=0 → no bus_valid, rsp_valid with rsp_fault=1 at N+1;
   - size 2 (4 bytes) with DATA_W=16 → fault.
